// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants: data width, default FIFO sizing, CPU I/O offsets and status bit layout.
package uart_tx_fifo_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_TX_DEPTH      = 16;
  localparam int UART_TX_LOW_WATER  = 4;

  localparam logic [7:0] UART_TXD   = 8'h00;
  localparam logic [7:0] UART_STAT  = 8'h04;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERFLOW = 2;
  localparam int STAT_TX_LOW   = 3;

  // Packs the flags into the STAT register layout the CPU reads.
  function automatic logic [3:0] uart_stat_pack(input logic irq_tx_low, input logic overflow,
                                                input logic full, input logic empty);
    logic [3:0] s;
    s                = '0;
    s[STAT_TX_LOW]   = irq_tx_low;
    s[STAT_OVERFLOW] = overflow;
    s[STAT_FULL]     = full;
    s[STAT_EMPTY]    = empty;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding the UART transmitter; registered level/full/empty/low-water flags.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH     = UART_TX_DEPTH,
  parameter int LOW_WATER = UART_TX_LOW_WATER,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   flush,
  input  logic                   clr_overflow,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            level,
  output logic                   overflow,
  output logic                   irq_tx_low
);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr;
  logic [AW:0]            level_nxt;
  logic                   push, pop, reject;

  // full is the registered flag, so a pop in the same cycle never frees a slot for the write
  assign push   = wr_en && !full && !flush;
  assign pop    = tx_valid && tx_ready && !flush;
  assign reject = wr_en && full && !flush;

  always_comb begin
    level_nxt = level;
    if (flush)
      level_nxt = '0;
    else if (push && !pop)
      level_nxt = level + 1'b1;
    else if (pop && !push)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      irq_tx_low <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      rd_ptr     <= flush ? '0 : (pop  ? rd_ptr + 1'b1 : rd_ptr);
      wr_ptr     <= flush ? '0 : (push ? wr_ptr + 1'b1 : wr_ptr);
      level      <= level_nxt;
      full       <= (level_nxt == (AW+1)'(DEPTH));
      empty      <= (level_nxt == '0);
      irq_tx_low <= (level_nxt <= (AW+1)'(LOW_WATER));
      // set beats clear
      if (reject)            overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = tx_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed + randomized bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int LOWW  = 4;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, flush, clr_overflow, tx_ready;
  logic [7:0] wr_data;
  logic       tx_valid, full, empty, overflow, irq_tx_low;
  logic [7:0] tx_data;
  logic [4:0] level;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q [$];
  logic       m_ovf;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .LOW_WATER(LOWW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clr_overflow(clr_overflow), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .irq_tx_low(irq_tx_low)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    int n;
    n = q.size();
    chk("level",    32'(level),      32'(n));
    chk("empty",    32'(empty),      32'(n == 0));
    chk("full",     32'(full),       32'(n == DEPTH));
    chk("tx_valid", 32'(tx_valid),   32'(n != 0));
    chk("overflow", 32'(overflow),   32'(m_ovf));
    chk("irq_low",  32'(irq_tx_low), 32'(n <= LOWW));
    if (n != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
  endtask

  // Drive one cycle, advance the model with the rules, then compare after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic f,
                      input logic c, input logic r);
    bit was_full, set;
    wr_en = w; wr_data = d; flush = f; clr_overflow = c; tx_ready = r;
    @(posedge clk);
    #1;
    was_full = (q.size() == DEPTH);
    set = w && was_full && !f;
    if (f) q.delete();
    else begin
      if (r && q.size() != 0) void'(q.pop_front());
      if (w && !was_full) q.push_back(d);
    end
    if (set) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    wr_en = 0; flush = 0; clr_overflow = 0; tx_ready = 0;
    chk_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 0; wr_data = 0; flush = 0; clr_overflow = 0; tx_ready = 0;
    q.delete(); m_ovf = 0;

    // reset state
    do_reset();
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_irq", 32'(irq_tx_low), 1);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(tx_data), 0);

    // single byte, show-ahead
    step(1, 8'h41, 0, 0, 0);
    chk("t1_data", 32'(tx_data), 32'h41);
    chk("t1_level", 32'(level), 1);
    step(0, 0, 0, 0, 1);

    // fill, overflow, drain in order
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    chk("t2_full", 32'(full), 1);
    step(1, 8'hFF, 0, 0, 0);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_level", 32'(level), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", 32'(tx_data), 32'(i));
      step(0, 0, 0, 0, 1);
    end

    // write while full and popped: dropped, overflow set
    step(0, 0, 0, 1, 0);
    chk("clr_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) step(1, 8'h20 + 8'(i), 0, 0, 0);
    step(1, 8'hEE, 0, 0, 1);
    chk("t3_level", 32'(level), 15);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_head", 32'(tx_data), 32'h21);

    // push+pop at level 5, then low-water crossing
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    chk("t4_lvl5", 32'(level), 5);
    step(1, 8'h77, 0, 0, 1);
    chk("t4_level", 32'(level), 5);
    chk("t4_irq0", 32'(irq_tx_low), 0);
    step(0, 0, 0, 0, 1);
    chk("t4_irq1", 32'(irq_tx_low), 1);

    // flush with concurrent write and pop
    for (int i = 0; i < 3; i++) step(1, 8'h50 + 8'(i), 0, 0, 0);
    chk("t5_lvl7", 32'(level), 7);
    step(1, 8'h99, 1, 0, 1);
    chk("t5_level", 32'(level), 0);
    chk("t5_valid", 32'(tx_valid), 0);
    chk("t5_ovf", 32'(overflow), 1);

    // reset mid-operation
    for (int i = 0; i < 9; i++) step(1, 8'(i * 3), 0, 0, 0);
    do_reset();
    chk("t6_level", 32'(level), 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_valid", 32'(tx_valid), 0);
    chk("t6_irq", 32'(irq_tx_low), 1);

    // pointer wrap with paired push/pop
    step(1, 8'hA0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), 0, 0, 1);
    chk("wrap_level", 32'(level), 1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
